// File: rtl/riscv_i32_trace_pkg.sv
// Shared definitions for the RISC-V i32 trace packer/decompressor pair:
// header bit positions, SYNC mode value, decoder FSM states and the
// trace bundle carried on the trace__* ports.
package riscv_i32_trace_pkg;

    // Header byte bit positions
    localparam int HDR_HAS_PC_BIT   = 0;
    localparam int HDR_BRANCH_BIT   = 1;
    localparam int HDR_TRAP_BIT     = 2;
    localparam int HDR_RFW_BIT      = 3;
    localparam int HDR_RFW_DV_BIT   = 4;
    localparam int HDR_MODE_LSB     = 5;
    localparam int HDR_MODE_MSB     = 7;

    // A header whose mode field carries this value is a SYNC marker
    localparam logic [2:0] MODE_SYNC = 3'b111;

    // Decoder states; ST_SYNC_PC loads the predicted PC without emitting
    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_PC      = 3'd1,
        ST_INSTR   = 3'd2,
        ST_RD      = 3'd3,
        ST_DATA    = 3'd4,
        ST_TGT     = 3'd5,
        ST_SYNC_PC = 3'd6
    } dec_state_e;

    // One retired instruction as seen on the trace bus
    typedef struct packed {
        logic        instr_valid;
        logic [31:0] instr_pc;
        logic [2:0]  mode;
        logic [31:0] instr_data;
        logic        rfw_retire;
        logic        rfw_data_valid;
        logic [4:0]  rfw_rd;
        logic [31:0] rfw_data;
        logic        branch_taken;
        logic [31:0] branch_target;
        logic        trap;
    } trace_t;

    // States that consume a 4-byte little-endian word
    function automatic logic is_word_state(dec_state_e s);
        return (s == ST_PC) || (s == ST_INSTR) || (s == ST_DATA) ||
               (s == ST_TGT) || (s == ST_SYNC_PC);
    endfunction

endpackage

// File: rtl/riscv_i32_trace_word_assembler.sv
// Collects four stream bytes, least significant first, into one 32-bit
// word. 'done' is high on the cycle the fourth byte is offered, and 'word'
// then already contains that byte, so the caller can use the full word on
// the same enabled edge that accepts it. The lane index wraps back to 0
// after every word, so one instance serves every 4-byte field in turn.
module riscv_i32_trace_word_assembler (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        done
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] low_q, low_d;

    // Next lane index and storage of the three low bytes
    always_comb begin
        idx_d = idx_q;
        low_d = low_q;
        if (byte_valid) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_d[7:0]   = byte_data;
                2'd1:    low_d[15:8]  = byte_data;
                2'd2:    low_d[23:16] = byte_data;
                default: low_d        = low_q;
            endcase
        end
    end

    // Lane index and partial word registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= 2'd0;
            low_q <= 24'h0;
        end else if (clk__enable) begin
            idx_q <= idx_d;
            low_q <= low_d;
        end
    end

    assign done = byte_valid && (idx_q == 2'd3);
    assign word = {byte_data, low_q};

endmodule

// File: rtl/riscv_i32_trace_decompress.sv
// Rebuilds the RISC-V i32 trace bus from a compressed byte stream.
// A byte-serial FSM parses header + body fields, tracks the predicted PC
// and raises trace__instr_valid for one enabled cycle per packet.
// Optional feature macro: RISCV_I32_TRACE_DECOMPRESS_COUNT_EN adds a live
// retired-instruction counter on instr_count (tied to 0 otherwise).
//
// Stream handshake: a byte transfers on an enabled clk edge when
// byte_in__valid=1 and byte_in_ready=1; ready is permanently 1, so the
// stream source alone paces the decoder, and valid=0 simply holds state.
module riscv_i32_trace_decompress #(
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        byte_in__valid,
    input  logic [7:0]  byte_in__data,
    output logic        byte_in_ready,
    output logic        trace__instr_valid,
    output logic [31:0] trace__instr_pc,
    output logic [2:0]  trace__instruction__mode,
    output logic [31:0] trace__instruction__data,
    output logic        trace__rfw_retire,
    output logic        trace__rfw_data_valid,
    output logic [4:0]  trace__rfw_rd,
    output logic [31:0] trace__rfw_data,
    output logic        trace__branch_taken,
    output logic [31:0] trace__branch_target,
    output logic        trace__trap,
    output logic        decode_error,
    output logic [31:0] instr_count
);

    import riscv_i32_trace_pkg::*;

    dec_state_e  state_q, state_d;

    // Header fields of the packet in flight
    logic        has_pc_q, has_pc_d;
    logic        br_q, br_d;
    logic        trap_q, trap_d;
    logic        rfw_q, rfw_d;
    logic        dv_q, dv_d;
    logic [2:0]  mode_q, mode_d;

    // Body fields that may be followed by further fields
    logic [31:0] pc_fld_q, pc_fld_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;

    // Decoder context kept across packets
    logic [31:0] pc_pred_q, pc_pred_d;
    logic        trap_pend_q, trap_pend_d;
    logic        err_q, err_d;
    trace_t      out_q, out_d;

    logic        asm_valid;
    logic        asm_done;
    logic [31:0] asm_word;
    logic        last;
    logic [31:0] tgt_w;
    logic [31:0] emit_pc;
    logic [2:0]  hdr_mode;

    assign hdr_mode  = byte_in__data[HDR_MODE_MSB:HDR_MODE_LSB];
    assign asm_valid = byte_in__valid && is_word_state(state_q);

    riscv_i32_trace_word_assembler u_word_asm (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset_n     (reset_n),
        .byte_valid  (asm_valid),
        .byte_data   (byte_in__data),
        .word        (asm_word),
        .done        (asm_done)
    );

    // Packet parser: next state, field capture, PC prediction and emission
    always_comb begin
        state_d     = state_q;
        has_pc_d    = has_pc_q;
        br_d        = br_q;
        trap_d      = trap_q;
        rfw_d       = rfw_q;
        dv_d        = dv_q;
        mode_d      = mode_q;
        pc_fld_d    = pc_fld_q;
        instr_d     = instr_q;
        rd_d        = rd_q;
        data_d      = data_q;
        pc_pred_d   = pc_pred_q;
        trap_pend_d = trap_pend_q;
        err_d       = err_q;
        out_d       = out_q;
        out_d.instr_valid = 1'b0;
        last        = 1'b0;
        tgt_w       = 32'h0;
        emit_pc     = has_pc_q ? pc_fld_q : pc_pred_q;

        case (state_q)
            ST_HDR: begin
                if (byte_in__valid) begin
                    if (hdr_mode == MODE_SYNC) begin
                        // SYNC never emits; it may only reload the prediction
                        state_d = byte_in__data[HDR_HAS_PC_BIT] ? ST_SYNC_PC : ST_HDR;
                    end else begin
                        has_pc_d = byte_in__data[HDR_HAS_PC_BIT];
                        br_d     = byte_in__data[HDR_BRANCH_BIT];
                        trap_d   = byte_in__data[HDR_TRAP_BIT];
                        rfw_d    = byte_in__data[HDR_RFW_BIT];
                        // Data-valid without a retire is malformed: flag it
                        // and decode as though data-valid were clear
                        dv_d     = byte_in__data[HDR_RFW_DV_BIT] && byte_in__data[HDR_RFW_BIT];
                        mode_d   = hdr_mode;
                        if (byte_in__data[HDR_RFW_DV_BIT] && !byte_in__data[HDR_RFW_BIT]) begin
                            err_d = 1'b1;
                        end
                        // A trap must be followed by an explicit PC
                        if (trap_pend_q && !byte_in__data[HDR_HAS_PC_BIT]) begin
                            err_d = 1'b1;
                        end
                        trap_pend_d = 1'b0;
                        state_d = byte_in__data[HDR_HAS_PC_BIT] ? ST_PC : ST_INSTR;
                    end
                end
            end
            ST_PC: begin
                if (asm_done) begin
                    pc_fld_d = asm_word;
                    state_d  = ST_INSTR;
                end
            end
            ST_INSTR: begin
                if (asm_done) begin
                    instr_d = asm_word;
                    if (rfw_q) begin
                        state_d = ST_RD;
                    end else if (br_q) begin
                        state_d = ST_TGT;
                    end else begin
                        last = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (byte_in__valid) begin
                    rd_d = byte_in__data[4:0];
                    if (dv_q) begin
                        state_d = ST_DATA;
                    end else if (br_q) begin
                        state_d = ST_TGT;
                    end else begin
                        last = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (asm_done) begin
                    data_d = asm_word;
                    if (br_q) begin
                        state_d = ST_TGT;
                    end else begin
                        last = 1'b1;
                    end
                end
            end
            ST_TGT: begin
                if (asm_done) begin
                    tgt_w = asm_word;
                    last  = 1'b1;
                end
            end
            ST_SYNC_PC: begin
                if (asm_done) begin
                    pc_pred_d = asm_word;
                    state_d   = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        if (last) begin
            state_d                = ST_HDR;
            out_d.instr_valid      = 1'b1;
            out_d.instr_pc         = emit_pc;
            out_d.mode             = mode_q;
            out_d.instr_data       = instr_d;
            out_d.rfw_retire       = rfw_q;
            out_d.rfw_data_valid   = dv_q;
            out_d.rfw_rd           = rfw_q ? rd_d : 5'd0;
            out_d.rfw_data         = dv_q ? data_d : 32'h0;
            out_d.branch_taken     = br_q;
            out_d.branch_target    = tgt_w;
            out_d.trap             = trap_q;
            pc_pred_d              = br_q ? tgt_w : emit_pc + 32'd4;
            trap_pend_d            = trap_q;
        end
    end

    // Decoder state, packet fields and trace output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HDR;
            has_pc_q    <= 1'b0;
            br_q        <= 1'b0;
            trap_q      <= 1'b0;
            rfw_q       <= 1'b0;
            dv_q        <= 1'b0;
            mode_q      <= 3'd0;
            pc_fld_q    <= 32'h0;
            instr_q     <= 32'h0;
            rd_q        <= 5'd0;
            data_q      <= 32'h0;
            pc_pred_q   <= PC_RESET;
            trap_pend_q <= 1'b0;
            err_q       <= 1'b0;
            out_q       <= '0;
        end else if (clk__enable) begin
            state_q     <= state_d;
            has_pc_q    <= has_pc_d;
            br_q        <= br_d;
            trap_q      <= trap_d;
            rfw_q       <= rfw_d;
            dv_q        <= dv_d;
            mode_q      <= mode_d;
            pc_fld_q    <= pc_fld_d;
            instr_q     <= instr_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            pc_pred_q   <= pc_pred_d;
            trap_pend_q <= trap_pend_d;
            err_q       <= err_d;
            out_q       <= out_d;
        end
    end

`ifdef RISCV_I32_TRACE_DECOMPRESS_COUNT_EN
    logic [31:0] count_q, count_d;

    // Count emitted instructions, wrapping at 2^32
    always_comb begin
        count_d = count_q + {31'd0, out_d.instr_valid};
    end

    // Instruction counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'h0;
        end else if (clk__enable) begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'h0;
`endif

    assign byte_in_ready            = 1'b1;
    assign trace__instr_valid       = out_q.instr_valid;
    assign trace__instr_pc          = out_q.instr_pc;
    assign trace__instruction__mode = out_q.mode;
    assign trace__instruction__data = out_q.instr_data;
    assign trace__rfw_retire        = out_q.rfw_retire;
    assign trace__rfw_data_valid    = out_q.rfw_data_valid;
    assign trace__rfw_rd            = out_q.rfw_rd;
    assign trace__rfw_data          = out_q.rfw_data;
    assign trace__branch_taken      = out_q.branch_taken;
    assign trace__branch_target     = out_q.branch_target;
    assign trace__trap              = out_q.trap;
    assign decode_error             = err_q;

endmodule
